// File: rtl/pipeline_hazard_control.sv
// Five-stage CPU control: decodes the IF/ID instruction and carries the control word through
// ID/EX, EX/MEM and MEM/WB. It also generates the interlock, flush, forwarding and event counts.
module pipeline_hazard_control #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4,
  parameter bit FORWARDING = 1'b1,
  parameter bit RF_BYPASS  = 1'b1,
  parameter int COUNT_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           if_inst,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_use_imm,
  output logic                  ex_shift,
  output logic                  ex_sign_ext,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_branch,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic [COUNT_W-1:0]    stall_count,
  output logic [COUNT_W-1:0]    flush_count
);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(8);

  typedef struct packed {
    logic [ALUOP_W-1:0]    alu_op;
    logic                  use_imm;
    logic                  shift;
    logic                  sign_ext;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  branch;
    logic [REG_ADDR_W-1:0] dst;
    logic [REG_ADDR_W-1:0] src_a;
    logic [REG_ADDR_W-1:0] src_b;
  } ctrl_t;

  typedef struct packed {
    logic                  branch;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dst;
  } mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dst;
  } wb_t;

  // Unused sources and non-writing destinations are zeroed so that register 0 never matches.
  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t                 c;
    logic [5:0]            op;
    logic [5:0]            fn;
    logic [REG_ADDR_W-1:0] rs, rt, rd, dst;
    logic                  valid, write, use_rs, use_rt;
    op = inst[31:26];
    fn = inst[5:0];
    rs = inst[21 +: REG_ADDR_W];
    rt = inst[16 +: REG_ADDR_W];
    rd = inst[11 +: REG_ADDR_W];
    c = '0;
    c.alu_op = ALU_ADD;
    valid  = 1'b1;
    write  = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    dst    = '0;
    case (op)
      6'h00: begin
        write  = 1'b1;
        dst    = rd;
        use_rs = 1'b1;
        use_rt = 1'b1;
        case (fn)
          6'h20: c.alu_op = ALU_ADD;
          6'h22: c.alu_op = ALU_SUB;
          6'h24: c.alu_op = ALU_AND;
          6'h25: c.alu_op = ALU_OR;
          6'h27: c.alu_op = ALU_NOR;
          6'h2A: c.alu_op = ALU_SLT;
          6'h00: begin c.alu_op = ALU_SLL; c.shift = 1'b1; use_rs = 1'b0; end
          6'h02: begin c.alu_op = ALU_SRL; c.shift = 1'b1; use_rs = 1'b0; end
          6'h03: begin c.alu_op = ALU_SRA; c.shift = 1'b1; use_rs = 1'b0; end
          default: valid = 1'b0;
        endcase
      end
      6'h08: begin
        c.use_imm = 1'b1; c.sign_ext = 1'b1; write = 1'b1; dst = rt; use_rs = 1'b1;
      end
      6'h0C: begin
        c.alu_op = ALU_AND; c.use_imm = 1'b1; write = 1'b1; dst = rt; use_rs = 1'b1;
      end
      6'h0D: begin
        c.alu_op = ALU_OR; c.use_imm = 1'b1; write = 1'b1; dst = rt; use_rs = 1'b1;
      end
      6'h23: begin
        c.use_imm = 1'b1; c.sign_ext = 1'b1; c.mem_to_reg = 1'b1;
        write = 1'b1; dst = rt; use_rs = 1'b1;
      end
      6'h2B: begin
        c.use_imm = 1'b1; c.sign_ext = 1'b1; c.mem_write = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      6'h04: begin
        c.alu_op = ALU_SUB; c.sign_ext = 1'b1; c.branch = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    if (valid) begin
      c.src_a     = use_rs ? rs : '0;
      c.src_b     = use_rt ? rt : '0;
      c.reg_write = write && (dst != '0);
      c.dst       = c.reg_write ? dst : '0;
    end else begin
      c = '0;
      c.alu_op = ALU_ADD;
    end
    return c;
  endfunction

  function automatic logic raw_hit(input logic wr, input logic [REG_ADDR_W-1:0] d, input ctrl_t c);
    return wr && (d != '0) && ((c.src_a == d) || (c.src_b == d));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src, input mem_t m, input wb_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != '0) begin
      if (m.reg_write && !m.mem_to_reg && (m.dst == src)) sel = 2'd1;
      else if (w.reg_write && (w.dst == src))             sel = 2'd2;
    end
    return sel;
  endfunction

  ctrl_t dec, ctrl_p0;
  mem_t  ctrl_p1;
  wb_t   ctrl_p2;
  logic  hazard;
  logic  unused_shamt;

  assign dec          = decode(if_inst);
  assign unused_shamt = ^if_inst[10:6];

  always_comb begin
    hazard = 1'b0;
    fwd_a  = 2'd0;
    fwd_b  = 2'd0;
    if (FORWARDING) begin
      hazard = ctrl_p0.mem_to_reg && raw_hit(ctrl_p0.reg_write, ctrl_p0.dst, dec);
      fwd_a  = fwd_sel(ctrl_p0.src_a, ctrl_p1, ctrl_p2);
      fwd_b  = fwd_sel(ctrl_p0.src_b, ctrl_p1, ctrl_p2);
    end else begin
      hazard = raw_hit(ctrl_p0.reg_write, ctrl_p0.dst, dec)
            || raw_hit(ctrl_p1.reg_write, ctrl_p1.dst, dec)
            || (!RF_BYPASS && raw_hit(ctrl_p2.reg_write, ctrl_p2.dst, dec));
    end
  end

  assign flush = ctrl_p1.branch & branch_taken;
  assign stall = hazard & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_p0     <= '0;
      ctrl_p1     <= '0;
      ctrl_p2     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // IF/ID -> ID/EX
      ctrl_p0 <= (stall || flush) ? '0 : dec;
      // ID/EX -> EX/MEM
      ctrl_p1 <= flush ? '0 : mem_t'{ctrl_p0.branch, ctrl_p0.mem_write, ctrl_p0.reg_write,
                                     ctrl_p0.mem_to_reg, ctrl_p0.dst};
      // EX/MEM -> MEM/WB
      ctrl_p2 <= wb_t'{ctrl_p1.reg_write, ctrl_p1.mem_to_reg, ctrl_p1.dst};
      if (stall) stall_count <= stall_count + COUNT_W'(1);
      if (flush) flush_count <= flush_count + COUNT_W'(1);
    end
  end

  assign ex_alu_op     = ctrl_p0.alu_op;
  assign ex_use_imm    = ctrl_p0.use_imm;
  assign ex_shift      = ctrl_p0.shift;
  assign ex_sign_ext   = ctrl_p0.sign_ext;
  assign mem_branch    = ctrl_p1.branch;
  assign mem_write     = ctrl_p1.mem_write;
  assign wb_reg_write  = ctrl_p2.reg_write;
  assign wb_mem_to_reg = ctrl_p2.mem_to_reg;
  assign wb_dst        = ctrl_p2.dst;

endmodule
